// File: rtl/ts_packet_gen.sv
// ts_packet_gen: MPEG-TS packet source with a forwarded byte clock.
// Emits 188-byte packets, one byte per TS_CLOCK_OUT period.
module ts_packet_gen #(
  parameter logic [12:0] PID       = 13'h0100,
  parameter int          GAP_BYTES = 4,
  parameter int          CLK_DIV   = 2
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic [15:0] PKT_LIMIT,
  output logic        TS_CLOCK_OUT,
  output logic        TS_VALID_OUT,
  output logic        TS_SYNC_OUT,
  output logic [7:0]  TS_DATA_OUT,
  output logic [15:0] PKT_COUNT,
  output logic        BUSY,
  output logic        DONE
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (GAP_BYTES > 1) ? $clog2(GAP_BYTES) : 1;

  localparam logic [DW-1:0] DIV_LAST =
    DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_BYTES > 0) ? GAP_BYTES - 1 : 0);
  localparam logic [7:0] LAST_IDX = 8'd187;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_BODY,
    S_GAP,
    S_DONE
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [DW-1:0] div_q;
  logic          tsclk_q;
  logic [7:0]    idx_q;
  logic [7:0]    idx_d;
  logic [GW-1:0] gap_q;
  logic [GW-1:0] gap_d;
  logic [15:0]   cnt_q;
  logic [15:0]   cnt_d;
  logic [3:0]    cc_q;
  logic [3:0]    cc_d;
  logic [15:0]   limit_q;
  logic [15:0]   limit_d;
  logic          valid_q;
  logic          valid_d;
  logic          sync_q;
  logic          sync_d;
  logic [7:0]    data_q;
  logic [7:0]    data_d;
  logic          busy_q;
  logic          busy_d;
  logic          done_q;
  logic          done_d;

  logic div_tc;
  logic slot_end;

  // Slot boundary is the edge where the TS clock falls.
  assign div_tc   = (div_q == DIV_LAST);
  assign slot_end = div_tc & tsclk_q;

  // Free-running divider producing the forwarded TS clock.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      div_q   <= '0;
      tsclk_q <= 1'b0;
    end else if (div_tc) begin
      div_q   <= '0;
      tsclk_q <= ~tsclk_q;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Packet sequencer, advanced once per byte slot.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    cc_d    = cc_q;
    limit_d = limit_q;
    if (slot_end) begin
      unique case (state_q)
        S_IDLE: begin
          if (ENABLE) begin
            state_d = S_SYNC;
            limit_d = PKT_LIMIT;
          end
        end
        S_SYNC: begin
          state_d = S_BODY;
          idx_d   = 8'd1;
        end
        S_BODY: begin
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + 8'd1;
          end else begin
            cnt_d = cnt_q + 16'd1;
            cc_d  = cc_q + 4'd1;
            if (limit_q != 16'd0 &&
                cnt_d == limit_q) begin
              state_d = S_DONE;
            end else if (GAP_BYTES > 0) begin
              state_d = S_GAP;
              gap_d   = '0;
            end else if (ENABLE) begin
              state_d = S_SYNC;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_d = ENABLE ? S_SYNC : S_IDLE;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        S_DONE: begin
          if (!ENABLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            cc_d    = '0;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Byte decoder for the slot that starts at this boundary.
  always_comb begin
    valid_d = valid_q;
    sync_d  = sync_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = done_q;
    if (slot_end) begin
      valid_d = (state_d == S_SYNC) ||
                (state_d == S_BODY);
      sync_d  = (state_d == S_SYNC);
      busy_d  = (state_d != S_IDLE) &&
                (state_d != S_DONE);
      done_d  = (state_d == S_DONE);
      data_d  = 8'h00;
      unique case (1'b1)
        (state_d == S_SYNC): begin
          data_d = 8'h47;
        end
        (state_d == S_BODY &&
         idx_d == 8'd1): begin
          data_d = {3'b010, PID[12:8]};
        end
        (state_d == S_BODY &&
         idx_d == 8'd2): begin
          data_d = PID[7:0];
        end
        (state_d == S_BODY &&
         idx_d == 8'd3): begin
          data_d = {4'b0001, cc_d};
        end
        (state_d == S_BODY &&
         idx_d > 8'd3): begin
          data_d = cnt_d[7:0] + idx_d - 8'd4;
        end
        default: begin
          data_d = 8'h00;
        end
      endcase
    end
  end

  // Sequencer state and registered TS outputs.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      cc_q    <= '0;
      limit_q <= '0;
      valid_q <= 1'b0;
      sync_q  <= 1'b0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      cc_q    <= cc_d;
      limit_q <= limit_d;
      valid_q <= valid_d;
      sync_q  <= sync_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign TS_CLOCK_OUT = tsclk_q;
  assign TS_VALID_OUT = valid_q;
  assign TS_SYNC_OUT  = sync_q;
  assign TS_DATA_OUT  = data_q;
  assign PKT_COUNT    = cnt_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;

endmodule

// File: tb/tb_ts_packet_gen.sv
// tb_ts_packet_gen: scoreboard bench for ts_packet_gen.
// Two instances: divide-by-2 with gaps, divide-by-1 back-to-back.
module tb_ts_packet_gen;

  logic        clk;
  logic        rst_n;
  logic        en_a;
  logic        en_b;
  logic [15:0] lim_a;
  logic [15:0] lim_b;

  logic        ts_a, valid_a, sync_a, busy_a, done_a;
  logic [7:0]  data_a;
  logic [15:0] cnt_a;
  logic        ts_b, valid_b, sync_b, busy_b, done_b;
  logic [7:0]  data_b;
  logic [15:0] cnt_b;

  ts_packet_gen #(
    .PID(13'h0100), .GAP_BYTES(4), .CLK_DIV(2)
  ) u_a (
    .CLOCK(clk), .RESET(rst_n), .ENABLE(en_a),
    .PKT_LIMIT(lim_a), .TS_CLOCK_OUT(ts_a),
    .TS_VALID_OUT(valid_a), .TS_SYNC_OUT(sync_a),
    .TS_DATA_OUT(data_a), .PKT_COUNT(cnt_a),
    .BUSY(busy_a), .DONE(done_a)
  );

  ts_packet_gen #(
    .PID(13'h0100), .GAP_BYTES(0), .CLK_DIV(1)
  ) u_b (
    .CLOCK(clk), .RESET(rst_n), .ENABLE(en_b),
    .PKT_LIMIT(lim_b), .TS_CLOCK_OUT(ts_b),
    .TS_VALID_OUT(valid_b), .TS_SYNC_OUT(sync_b),
    .TS_DATA_OUT(data_b), .PKT_COUNT(cnt_b),
    .BUSY(busy_b), .DONE(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       sync;
    bit         first;
    int         idx;
    int         pkt;
  } exp_t;

  typedef struct {
    logic [15:0] limit;
    logic [15:0] late;
    logic [15:0] exp_cnt;
  } vec_t;

  exp_t sb0[$];
  exp_t sb1[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise[2];
  int gap_cnt[2];
  int last_idx[2];
  int cur_pkt[2];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, req);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k,
                                          input int n);
    logic [7:0] kb;
    logic [3:0] cc;
    kb = k[7:0];
    cc = k[3:0];
    case (n)
      0:       return 8'h47;
      1:       return 8'h41;
      2:       return 8'h00;
      3:       return {4'h1, cc};
      default: return kb + 8'(n - 4);
    endcase
  endfunction

  task automatic push_pkt(input int u, input int k,
                          input bit first);
    exp_t e;
    for (int n = 0; n < 188; n++) begin
      e.data  = exp_byte(k, n);
      e.sync  = (n == 0);
      e.first = first && (n == 0);
      e.idx   = n;
      e.pkt   = k;
      if (u == 0) sb0.push_back(e);
      else        sb1.push_back(e);
    end
  endtask

  task automatic mon(input int u, input logic v,
                     input logic s, input logic [7:0] d,
                     input logic b, input int gexp);
    exp_t  e;
    string p;
    int    sz;
    p  = (u == 0) ? "a_" : "b_";
    sz = (u == 0) ? sb0.size() : sb1.size();
    if (v) begin
      if (sz == 0) begin
        checks++;
        errors++;
        $display("FAIL %sunexpected: got byte %0h expected none",
                 p, d);
      end else begin
        e = (u == 0) ? sb0.pop_front() : sb1.pop_front();
        check({p, "data"}, d, e.data);
        check({p, "sync"}, s, e.sync);
        check({p, "busy"}, b, 1);
        if (s && !e.first)
          check({p, "gap"}, gap_cnt[u], gexp);
        last_idx[u] = e.idx;
        cur_pkt[u]  = e.pkt;
      end
      gap_cnt[u] = 0;
    end else begin
      check({p, "idle_data"}, d, 8'h00);
      check({p, "idle_sync"}, s, 1'b0);
      if (last_idx[u] >= 0 && last_idx[u] != 187) begin
        checks++;
        errors++;
        $display("FAIL %svalid_drop: got VALID=0 after byte %0d expected 1",
                 p, last_idx[u]);
      end
      gap_cnt[u]++;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      last_rise[0] = -1;
      last_rise[1] = -1;
    end
  end

  always @(posedge ts_a) begin
    if (last_rise[0] >= 0)
      check("a_period", cyc - last_rise[0], 4);
    last_rise[0] = cyc;
    mon(0, valid_a, sync_a, data_a, busy_a, 4);
  end

  always @(posedge ts_b) begin
    if (last_rise[1] >= 0)
      check("b_period", cyc - last_rise[1], 2);
    last_rise[1] = cyc;
    mon(1, valid_b, sync_b, data_b, busy_b, 0);
  end

  task automatic run_a(input logic [15:0] lim,
                       input logic [15:0] late,
                       input logic [15:0] exp_cnt);
    bit ok;
    int budget;
    for (int k = 0; k < int'(exp_cnt); k++)
      push_pkt(0, k, k == 0);
    lim_a = lim;
    en_a  = 1'b1;
    repeat (40) @(negedge clk);
    lim_a = late;
    ok = 1'b0;
    budget = int'(exp_cnt) * 800 + 200;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_a) begin
        ok = 1'b1;
        break;
      end
    end
    check("a_done_reached", ok, 1);
    check("a_done_count", cnt_a, exp_cnt);
    check("a_done_flag", done_a, 1);
    check("a_done_busy", busy_a, 0);
    check("a_done_valid", valid_a, 0);
    check("a_done_data", data_a, 8'h00);
    check("a_sb_empty", sb0.size(), 0);
    en_a = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!done_a) begin
        ok = 1'b1;
        break;
      end
    end
    check("a_done_clear", ok, 1);
    check("a_restart_count", cnt_a, 0);
    check("a_restart_busy", busy_a, 0);
  endtask

  vec_t tbl[3];
  bit   hit;

  initial begin
    tbl[0] = '{16'd1,  16'd5, 16'd1};
    tbl[1] = '{16'd17, 16'd2, 16'd17};
    tbl[2] = '{16'd3,  16'd1, 16'd3};

    for (int u = 0; u < 2; u++) begin
      gap_cnt[u]   = 0;
      last_idx[u]  = -1;
      cur_pkt[u]   = -1;
      last_rise[u] = -1;
    end

    rst_n = 1'b0;
    en_a  = 1'b0;
    en_b  = 1'b0;
    lim_a = '0;
    lim_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_clk", ts_a, 0);
    check("rst_a_valid", valid_a, 0);
    check("rst_a_sync", sync_a, 0);
    check("rst_a_data", data_a, 8'h00);
    check("rst_a_count", cnt_a, 0);
    check("rst_a_busy", busy_a, 0);
    check("rst_a_done", done_a, 0);
    check("rst_b_clk", ts_b, 0);
    check("rst_b_valid", valid_b, 0);
    check("rst_b_count", cnt_b, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 3; t++)
      run_a(tbl[t].limit, tbl[t].late, tbl[t].exp_cnt);

    last_idx[0] = -1;
    cur_pkt[0]  = -1;
    push_pkt(0, 0, 1'b1);
    lim_a = 16'd0;
    en_a  = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cur_pkt[0] == 0 && last_idx[0] >= 100) begin
        hit = 1'b1;
        break;
      end
    end
    check("a_reach_byte100", hit, 1);
    rst_n = 1'b0;
    en_a  = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_clk", ts_a, 0);
    check("mid_rst_valid", valid_a, 0);
    check("mid_rst_sync", sync_a, 0);
    check("mid_rst_data", data_a, 8'h00);
    check("mid_rst_count", cnt_a, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_done", done_a, 0);
    sb0.delete();
    last_idx[0] = -1;
    last_idx[1] = -1;
    @(negedge clk);
    rst_n = 1'b1;
    run_a(16'd1, 16'd4, 16'd1);

    for (int k = 0; k < 3; k++)
      push_pkt(1, k, k == 0);
    lim_b = 16'd0;
    en_b  = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (cur_pkt[1] == 2 && last_idx[1] >= 50) begin
        hit = 1'b1;
        break;
      end
    end
    check("b_reach_byte50", hit, 1);
    en_b = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy_b) begin
        hit = 1'b1;
        break;
      end
    end
    check("b_busy_fall", hit, 1);
    repeat (20) @(negedge clk);
    check("b_idle_count", cnt_b, 3);
    check("b_idle_valid", valid_b, 0);
    check("b_idle_done", done_b, 0);
    check("b_idle_busy", busy_b, 0);
    check("b_sb_empty", sb1.size(), 0);
    check("b_last_idx", last_idx[1], 187);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
